// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - RV32 opcode and funct3 encodings for loads and stores
//   - exception cause and FSM state enumerations
//   - helpers that build the store byte-enable mask and lane-replicated data
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_MISALIGN = 2'b01,
        CAUSE_ILLEGAL  = 2'b10,
        CAUSE_TIMEOUT  = 2'b11
    } lsu_cause_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } lsu_state_t;

    // Byte enables for a store of width funct3 at byte offset addr_lo.
    function automatic logic [3:0] store_wstrb(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (funct3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = 4'b0011 << {addr_lo[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data replicated across all lanes so the strobes alone pick the bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] data);
        logic [31:0] wd;
        case (funct3)
            F3_B:    wd = {4{data[7:0]}};
            F3_H:    wd = {2{data[15:0]}};
            default: wd = data;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/rv32_load_align.sv
// -----------------------------------------------------------------------------
// rv32_load_align
// Combinational load lane select and extension.
// Ports:
//   rdata   in  32  raw word returned by data memory
//   addr_lo in   2  byte offset of the access within the word
//   funct3  in   3  load width/signedness (LB/LH/LW/LBU/LHU)
//   result  out 32  extended load value
// -----------------------------------------------------------------------------
module rv32_load_align
    import rv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_BU:   result = {24'd0, byte_sel};
            F3_HU:   result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/rv32_mem_lsu.sv
// -----------------------------------------------------------------------------
// rv32_mem_lsu
// MEM-stage load/store unit. Decodes the EX/MEM instruction, runs a single
// outstanding req/ack data-memory transaction, stalls the pipeline while it is
// in flight, extends load data and reports misaligned/illegal/timeout faults.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   code_in, alu_res_in      instruction and effective address
//   bshift_in                store data (rs2)
//   flush_in                 kill the current op
//   stall_out                hold EX/MEM and upstream
//   mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ack   data bus
//   load_data_out, load_valid_out   load result and its 1-cycle strobe
//   excp_out, excp_cause_out        1-cycle exception pulse and cause
// -----------------------------------------------------------------------------
module rv32_mem_lsu
    import rv32_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] bshift_in,
    input  logic        flush_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        excp_out,
    output logic [1:0]  excp_cause_out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t state_reg, state_next;

    logic             mem_req_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;
    logic [3:0]       mem_wstrb_reg;
    logic [2:0]       funct3_reg;
    logic [1:0]       addr_lo_reg;
    logic             flushed_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [31:0]      load_data_reg;
    logic             excp_reg;
    lsu_cause_t       cause_reg;

    // ---------------- decode ----------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store;
    logic        f3_legal, aligned;
    logic        timeout_hold;
    logic        mem_op, accept, fault;
    lsu_cause_t  fault_cause;
    logic        kill;
    logic        cnt_done;
    logic [31:0] align_result;
    logic        unused_code_bits;

    assign opcode   = code_in[6:0];
    assign funct3   = code_in[14:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign unused_code_bits = ^{code_in[31:15], code_in[11:7]};

    always_comb begin
        f3_legal = 1'b0;
        if (is_load)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        else if (is_store)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end

    always_comb begin
        aligned = 1'b1;
        case (funct3)
            F3_H, F3_HU: aligned = (alu_res_in[0] == 1'b0);
            F3_W:        aligned = (alu_res_in[1:0] == 2'b00);
            default:     aligned = 1'b1;
        endcase
    end

    // After a bus timeout the faulting instruction is still sitting in EX/MEM
    // during the IDLE cycle that carries the exception pulse. It must be let
    // through (stall released) rather than re-issued to the bus.
    assign timeout_hold = excp_reg && (cause_reg == CAUSE_TIMEOUT);

    assign mem_op      = (is_load || is_store) && !flush_in && !timeout_hold;
    assign accept      = (state_reg == ST_IDLE) && mem_op && f3_legal && aligned;
    assign fault       = (state_reg == ST_IDLE) && mem_op && !(f3_legal && aligned);
    assign fault_cause = !f3_legal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;

    // A flush seen at any point of the BUSY phase kills the op's results.
    assign kill     = flushed_reg || flush_in;
    assign cnt_done = (cnt_reg == CNT_LAST);

    rv32_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_reg),
        .funct3  (funct3_reg),
        .result  (align_result)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_BUSY;
            ST_BUSY: begin
                if (mem_ack)
                    state_next = kill ? ST_IDLE : ST_RESP;
                else if (cnt_done)
                    state_next = ST_IDLE;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        stall_out      = 1'b0;
        load_valid_out = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_IDLE: stall_out = accept;
                ST_BUSY: stall_out = 1'b1;
                ST_RESP: load_valid_out = !mem_we_reg && !flush_in;
                default: stall_out = 1'b0;
            endcase
        end
    end

    assign mem_req        = mem_req_reg;
    assign mem_we         = mem_we_reg;
    assign mem_addr       = mem_addr_reg;
    assign mem_wdata      = mem_wdata_reg;
    assign mem_wstrb      = mem_wstrb_reg;
    assign load_data_out  = load_data_reg;
    assign excp_out       = excp_reg;
    assign excp_cause_out = cause_reg;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_wstrb_reg <= 4'd0;
            funct3_reg    <= 3'd0;
            addr_lo_reg   <= 2'd0;
            flushed_reg   <= 1'b0;
            cnt_reg       <= '0;
            load_data_reg <= 32'd0;
            excp_reg      <= 1'b0;
            cause_reg     <= CAUSE_NONE;
        end else begin
            excp_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= is_store;
                        mem_addr_reg  <= {alu_res_in[31:2], 2'b00};
                        mem_wdata_reg <= is_store ? store_wdata(funct3, bshift_in) : 32'd0;
                        mem_wstrb_reg <= is_store ? store_wstrb(funct3, alu_res_in[1:0]) : 4'd0;
                        funct3_reg    <= funct3;
                        addr_lo_reg   <= alu_res_in[1:0];
                        flushed_reg   <= 1'b0;
                        cnt_reg       <= '0;
                    end else if (fault) begin
                        excp_reg  <= 1'b1;
                        cause_reg <= fault_cause;
                    end
                end
                ST_BUSY: begin
                    if (flush_in)
                        flushed_reg <= 1'b1;
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        if (!mem_we_reg && !kill)
                            load_data_reg <= align_result;
                    end else if (cnt_done) begin
                        mem_req_reg <= 1'b0;
                        if (!kill) begin
                            excp_reg  <= 1'b1;
                            cause_reg <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_lsu.sv
module tb_rv32_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] code_in, alu_res_in, bshift_in;
    logic        flush_in;
    logic        stall_out, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] load_data_out;
    logic        load_valid_out, excp_out;
    logic [1:0]  excp_cause_out;

    int n_asserts = 0;
    int n_fail    = 0;

    // Values captured in the first BUSY cycle of an access
    int          stall_cnt;
    logic        obs_req, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    rv32_mem_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .code_in        (code_in),
        .alu_res_in     (alu_res_in),
        .bshift_in      (bshift_in),
        .flush_in       (flush_in),
        .stall_out      (stall_out),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .load_data_out  (load_data_out),
        .load_valid_out (load_valid_out),
        .excp_out       (excp_out),
        .excp_cause_out (excp_cause_out)
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an op in IDLE, leave wait_cyc BUSY cycles without ack, then ack.
    // Returns in the RESP cycle, 2 time units after the edge.
    task automatic access(input logic [31:0] code, input logic [31:0] addr,
                          input logic [31:0] data, input int wait_cyc,
                          input logic [31:0] rdata);
        code_in = code; alu_res_in = addr; bshift_in = data;
        #1 stall_cnt = int'(stall_out);
        tick(); #1;
        obs_req = mem_req; obs_we = mem_we; obs_addr = mem_addr;
        obs_wdata = mem_wdata; obs_wstrb = mem_wstrb;
        for (int i = 0; i < wait_cyc; i++) begin
            stall_cnt += int'(stall_out);
            tick(); #1;
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        stall_cnt += int'(stall_out);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'h0;
        #1;
    endtask

    initial begin
        rst = 1'b1; code_in = NOP; alu_res_in = 0; bshift_in = 0;
        flush_in = 1'b0; mem_rdata = 0; mem_ack = 1'b0;
        tick(); tick();
        #1;
        chk("rst_stall", stall_out, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_excp", excp_out, 0);
        chk("rst_lvalid", load_valid_out, 0);
        chk("rst_ldata", load_data_out, 0);
        rst = 1'b0;
        tick();

        // LW 0x100, ack two cycles after req
        access(mk(7'b0000011, 3'b010), 32'h100, 0, 2, 32'hDEADBEEF);
        chk("lw_req", obs_req, 1);
        chk("lw_we", obs_we, 0);
        chk("lw_addr", obs_addr, 32'h100);
        chk("lw_wstrb", obs_wstrb, 4'b0000);
        chk("lw_stall_cycles", stall_cnt, 4);
        chk("lw_resp_stall", stall_out, 0);
        chk("lw_resp_req", mem_req, 0);
        chk("lw_valid", load_valid_out, 1);
        chk("lw_data", load_data_out, 32'hDEADBEEF);
        code_in = NOP;
        tick(); #1;
        chk("lw_valid_pulse", load_valid_out, 0);

        // LB / LBU at 0x103 with same-cycle ack (minimum latency)
        access(mk(7'b0000011, 3'b000), 32'h103, 0, 0, 32'h80FF_FF7F);
        chk("lb_stall_cycles", stall_cnt, 2);
        chk("lb_data", load_data_out, 32'hFFFFFF80);
        chk("lb_valid", load_valid_out, 1);
        code_in = NOP; tick();
        access(mk(7'b0000011, 3'b100), 32'h103, 0, 0, 32'h80FF_FF7F);
        chk("lbu_data", load_data_out, 32'h00000080);
        code_in = NOP; tick();

        // SH 0x202
        access(mk(7'b0100011, 3'b001), 32'h202, 32'h1234ABCD, 1, 32'hFFFF_FFFF);
        chk("sh_we", obs_we, 1);
        chk("sh_addr", obs_addr, 32'h200);
        chk("sh_wstrb", obs_wstrb, 4'b1100);
        chk("sh_wdata", obs_wdata, 32'hABCDABCD);
        chk("sh_valid", load_valid_out, 0);
        chk("sh_ldata_kept", load_data_out, 32'h00000080);
        code_in = NOP; tick();

        // Misaligned LW
        code_in = mk(7'b0000011, 3'b010); alu_res_in = 32'h101;
        #1 chk("mis_stall", stall_out, 0);
        tick(); #1;
        chk("mis_excp", excp_out, 1);
        chk("mis_cause", excp_cause_out, 2'b01);
        chk("mis_req", mem_req, 0);
        code_in = NOP;
        tick(); #1;
        chk("mis_excp_pulse", excp_out, 0);

        // Illegal store funct3
        code_in = mk(7'b0100011, 3'b011); alu_res_in = 32'h300;
        #1 chk("ill_stall", stall_out, 0);
        tick(); #1;
        chk("ill_excp", excp_out, 1);
        chk("ill_cause", excp_cause_out, 2'b10);
        chk("ill_req", mem_req, 0);
        code_in = NOP;
        tick();

        // Timeout: SW with no ack
        code_in = mk(7'b0100011, 3'b010); alu_res_in = 32'h300; bshift_in = 32'h55AA55AA;
        tick();                              // BUSY, counter 0
        for (int i = 0; i < 15; i++) tick(); // BUSY, counter 15
        #1;
        chk("to_req_last", mem_req, 1);
        chk("to_stall_last", stall_out, 1);
        chk("to_excp_early", excp_out, 0);
        tick(); #1;
        chk("to_req_drop", mem_req, 0);
        chk("to_excp", excp_out, 1);
        chk("to_cause", excp_cause_out, 2'b11);
        chk("to_stall_rel", stall_out, 0);
        code_in = NOP;
        tick(); #1;
        chk("to_excp_pulse", excp_out, 0);

        // Reset in the middle of a BUSY access
        code_in = mk(7'b0000011, 3'b010); alu_res_in = 32'h400;
        tick(); tick();
        #1 chk("rstb_req_before", mem_req, 1);
        rst = 1'b1;
        #1 chk("rstb_stall_during", stall_out, 0);
        tick(); #1;
        chk("rstb_req", mem_req, 0);
        chk("rstb_addr", mem_addr, 0);
        chk("rstb_wdata", mem_wdata, 0);
        chk("rstb_ldata", load_data_out, 0);
        chk("rstb_cause", excp_cause_out, 0);
        chk("rstb_stall", stall_out, 0);
        rst = 1'b0; code_in = NOP;
        tick(); #1;
        chk("rstb_idle_stall", stall_out, 0);

        // Flush during BUSY, then ack
        code_in = mk(7'b0000011, 3'b010); alu_res_in = 32'h500;
        tick();                    // BUSY
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1 chk("fl_stall_busy", stall_out, 1);
        tick();
        mem_ack = 1'b0; code_in = NOP;
        #1;
        chk("fl_valid", load_valid_out, 0);
        chk("fl_excp", excp_out, 0);
        chk("fl_req", mem_req, 0);
        chk("fl_stall", stall_out, 0);
        chk("fl_ldata_kept", load_data_out, 0);

        // LHU 0x2
        access(mk(7'b0000011, 3'b101), 32'h2, 0, 0, 32'hF00D0000);
        chk("lhu_data", load_data_out, 32'h0000F00D);
        chk("lhu_valid", load_valid_out, 1);
        code_in = NOP; tick();

        // LH 0x2 with flush in RESP: data captured, strobe suppressed
        access(mk(7'b0000011, 3'b001), 32'h2, 0, 0, 32'hF00D0000);
        flush_in = 1'b1;
        #1;
        chk("lh_data", load_data_out, 32'hFFFFF00D);
        chk("lh_flush_valid", load_valid_out, 0);
        flush_in = 1'b0; code_in = NOP;
        tick();

        // Stray ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("stray_valid", load_valid_out, 0);
        chk("stray_req", mem_req, 0);
        chk("stray_ldata", load_data_out, 32'hFFFFF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule
